pulse_to_level: RTL and testbench

- Multi-channel pulse stretcher. Per channel, a single-cycle (or longer) trigger pulse becomes a clean level that stays high for a programmable number of clock cycles.
- It is the inverse of the team's level-to-pulse edge detector. It drives slow consumers (LED drivers, status registers, cross-board trigger lines, slower clock domains) from one-cycle event pulses produced inside the DIF logic.
- Channels are independent. A shared stretch length and a retrigger policy are applied to every channel.

---
 rtl/pulse_to_level.sv | 62 ++++++
 tb/tb_pulse_to_level.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_to_level.sv
// Multi-channel pulse stretcher: each trigger becomes a level held for len cycles (len=0 acts as 1).
// Latency: level rises 1 cycle after the trigger edge; no backpressure, triggers dropped while en is low.
module pulse_to_level #(
   parameter int SIZE   = 8,
   parameter int CNT_W  = 8,
   parameter int RETRIG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] len,
   input  logic [SIZE-1:0]  din,
   input  logic             clr_missed,
   output logic [SIZE-1:0]  dout,
   output logic             busy,
   output logic [SIZE-1:0]  missed
);

   logic [CNT_W-1:0] cnt     [SIZE];
   logic [CNT_W-1:0] cnt_nxt [SIZE];
   logic [SIZE-1:0]  dout_nxt;
   logic [SIZE-1:0]  miss_set;
   logic [SIZE-1:0]  trig;
   logic [CNT_W-1:0] load_val;

   assign trig     = din & {SIZE{en}};
   assign load_val = (len == '0) ? CNT_W'(1) : len;

   always_comb begin
      dout_nxt = '0;
      miss_set = '0;
      for (int i = 0; i < SIZE; i++) begin
         cnt_nxt[i] = cnt[i];
         if (cnt[i] == '0) begin
            if (trig[i]) cnt_nxt[i] = load_val;
         end else if (trig[i] && (RETRIG != 0)) begin
            cnt_nxt[i] = load_val;
         end else begin
            // Without retrigger, a trigger on an active channel (even on its last cycle) is dropped.
            cnt_nxt[i]  = cnt[i] - CNT_W'(1);
            miss_set[i] = trig[i];
         end
         dout_nxt[i] = (cnt_nxt[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '{default: '0};
         dout   <= '0;
         busy   <= 1'b0;
         missed <= '0;
      end else begin
         cnt    <= cnt_nxt;
         dout   <= dout_nxt;
         busy   <= |dout_nxt;
         // A new miss wins over a simultaneous clear.
         missed <= (clr_missed ? '0 : missed) | miss_set;
      end
   end

endmodule

// File: tb/tb_pulse_to_level.sv
// Bench for pulse_to_level: one retriggering and one non-retriggering instance on shared inputs,
// checked each cycle against an end-time model plus hand-computed literal expectations.
module tb_pulse_to_level;

   localparam int SIZE  = 8;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [CNT_W-1:0] len;
   logic [SIZE-1:0]  din;
   logic             clr_missed;

   logic [SIZE-1:0]  dout_rt, missed_rt, dout_nr, missed_nr;
   logic             busy_rt, busy_nr;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   pulse_to_level #(.SIZE(SIZE), .CNT_W(CNT_W), .RETRIG(1)) u_rt (
      .clk(clk), .rst(rst), .en(en), .len(len), .din(din), .clr_missed(clr_missed),
      .dout(dout_rt), .busy(busy_rt), .missed(missed_rt)
   );

   pulse_to_level #(.SIZE(SIZE), .CNT_W(CNT_W), .RETRIG(0)) u_nr (
      .clk(clk), .rst(rst), .en(en), .len(len), .din(din), .clr_missed(clr_missed),
      .dout(dout_nr), .busy(busy_nr), .missed(missed_nr)
   );

   // Model: each channel is high after edge m exactly when m < end time of its current stretch.
   int          cyc = 0;
   int          end_rt [SIZE];
   int          end_nr [SIZE];
   logic [SIZE-1:0] mis_nr = '0;
   logic        model_ok = 1'b0;
   int          l_eff;

   assign l_eff = (len == '0) ? 1 : int'(len);

   initial begin
      for (int i = 0; i < SIZE; i++) begin
         end_rt[i] = -10;
         end_nr[i] = -10;
      end
   end

   function automatic logic [SIZE-1:0] nr_misses();
      logic [SIZE-1:0] m = '0;
      for (int i = 0; i < SIZE; i++)
         if (en && din[i] && (cyc - 1 < end_nr[i])) m[i] = 1'b1;
      return m;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SIZE; i++) begin
            end_rt[i] <= cyc;
            end_nr[i] <= cyc;
         end
         mis_nr   <= '0;
         model_ok <= 1'b1;
      end else begin
         for (int i = 0; i < SIZE; i++) begin
            if (en && din[i]) begin
               end_rt[i] <= cyc + l_eff;
               if (!(cyc - 1 < end_nr[i])) end_nr[i] <= cyc + l_eff;
            end
         end
         mis_nr <= (clr_missed ? '0 : mis_nr) | nr_misses();
      end
      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (model_ok) begin
         logic [SIZE-1:0] er, en_;
         for (int i = 0; i < SIZE; i++) begin
            er[i]  = (cyc - 1 < end_rt[i]);
            en_[i] = (cyc - 1 < end_nr[i]);
         end
         check("model dout_rt",   32'(dout_rt),   32'(er));
         check("model busy_rt",   32'(busy_rt),   32'(|er));
         check("model missed_rt", 32'(missed_rt), 32'(0));
         check("model dout_nr",   32'(dout_nr),   32'(en_));
         check("model busy_nr",   32'(busy_nr),   32'(|en_));
         check("model missed_nr", 32'(missed_nr), 32'(mis_nr));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      logic [8:0] t_rt2, t_nr3, t_mis3, t_d07, t_d1, t_busy;
      logic [SIZE-1:0] din_tab [9];

      rst = 1'b1; en = 1'b1; len = '0; din = '0; clr_missed = 1'b0;

      // Reset then idle
      for (int k = 0; k < 2; k++) begin
         tick();
         check("reset dout_rt", 32'(dout_rt), 32'(0));
         check("reset busy_rt", 32'(busy_rt), 32'(0));
         check("reset missed_nr", 32'(missed_nr), 32'(0));
         check("reset dout_nr", 32'(dout_nr), 32'(0));
      end
      rst = 1'b0;
      tick();

      // Single pulse, len=5, then len=0
      len = 8'd5; din = 8'h01;
      for (int k = 0; k < 6; k++) begin
         tick();
         din = '0;
         check("single len5 dout0", 32'(dout_rt[0]), (k < 5) ? 32'd1 : 32'd0);
         check("single len5 busy",  32'(busy_nr),    (k < 5) ? 32'd1 : 32'd0);
      end
      len = 8'd0; din = 8'h01;
      for (int k = 0; k < 2; k++) begin
         tick();
         din = '0;
         check("single len0 dout0", 32'(dout_nr[0]), (k < 1) ? 32'd1 : 32'd0);
      end
      tick();

      // Retrigger: ch2 pulses at edges 0,2; ch3 at edges 0,2,3; clr_missed at edge 8
      t_rt2  = 9'b000111111;
      t_nr3  = 9'b000001111;
      t_mis3 = 9'b011111100;
      for (int e = 0; e < 9; e++) din_tab[e] = '0;
      din_tab[0] = 8'h0C; din_tab[2] = 8'h0C; din_tab[3] = 8'h08;
      len = 8'd4;
      for (int e = 0; e < 9; e++) begin
         din = din_tab[e];
         clr_missed = (e == 8);
         tick();
         check("retrig rt dout2",  32'(dout_rt[2]),   32'(t_rt2[e]));
         check("retrig rt missed2", 32'(missed_rt[2]), 32'(0));
         check("noretrig nr dout3", 32'(dout_nr[3]),  32'(t_nr3[e]));
         check("noretrig missed3",  32'(missed_nr[3]), 32'(t_mis3[e]));
      end
      din = '0; clr_missed = 1'b0;
      tick();

      // Clear together with a new miss: set wins
      din = 8'h08; tick();
      clr_missed = 1'b1; tick();
      check("clr+miss missed3", 32'(missed_nr[3]), 32'd1);
      din = '0; clr_missed = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      clr_missed = 1'b1; tick();
      clr_missed = 1'b0;
      check("clr missed", 32'(missed_nr), 32'd0);

      // en low discards triggers without flagging misses
      en = 1'b0; din = 8'hFF;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("en0 dout_rt", 32'(dout_rt), 32'd0);
         check("en0 dout_nr", 32'(dout_nr), 32'd0);
         check("en0 missed",  32'(missed_nr), 32'd0);
      end
      en = 1'b1; din = '0;
      tick();

      // Reset mid-stretch truncates; a fresh pulse restarts the full length
      len = 8'd10; din = 8'h02;
      tick(); din = '0;
      check("rststretch start", 32'(dout_rt[1]), 32'd1);
      tick(); tick();
      check("rststretch mid", 32'(dout_nr[1]), 32'd1);
      rst = 1'b1; tick();
      check("rststretch cut rt", 32'(dout_rt[1]), 32'd0);
      check("rststretch cut busy", 32'(busy_rt), 32'd0);
      rst = 1'b0; tick();
      din = 8'h02;
      for (int k = 0; k < 11; k++) begin
         tick(); din = '0;
         check("restart len10 dout1", 32'(dout_rt[1]), (k < 10) ? 32'd1 : 32'd0);
      end

      // Multi-channel independence
      t_d07  = 9'b000000111;
      t_d1   = 9'b011111110;
      t_busy = 9'b011111111;
      len = 8'd3; din = 8'h81;
      for (int e = 0; e < 9; e++) begin
         tick();
         if (e == 0) begin len = 8'd7; din = 8'h02; end
         else din = '0;
         check("multi dout0", 32'(dout_rt[0]), 32'(t_d07[e]));
         check("multi dout7", 32'(dout_nr[7]), 32'(t_d07[e]));
         check("multi dout1", 32'(dout_rt[1]), 32'(t_d1[e]));
         check("multi busy",  32'(busy_nr),    32'(t_busy[e]));
      end

      // Continuous trigger with a mid-run len change (model-checked)
      len = 8'd2; din = 8'h10;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k == 6) len = 8'd3;
      end
      tick();
      check("hold rt dout4", 32'(dout_rt[4]), 32'd1);
      din = '0;
      for (int k = 0; k < 5; k++) tick();
      check("final idle busy", 32'(busy_rt | busy_nr), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
